// File: rtl/split_cmd_data_fifo.sv
// split_cmd_data_fifo: command FIFO with a side queue that holds data for write commands only.
// Define SPLIT_FIFO_FLUSH_EN to add flush_i, which empties both queues without touching storage.
module split_cmd_data_fifo #(
   parameter int CMD_DEPTH  = 12,
   parameter int DATA_DEPTH = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int IDX_W      = 4,
   parameter int AFULL_THR  = CMD_DEPTH - 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
`ifdef SPLIT_FIFO_FLUSH_EN
   input  logic                              flush_i,
`endif
   input  logic                              valid_i,
   output logic                              grant_o,
   input  logic                              wr_i,
   input  logic [ADDR_W-1:0]                 addr_i,
   input  logic [DATA_W-1:0]                 data_i,
   input  logic [IDX_W-1:0]                  index_i,
   output logic                              valid_o,
   input  logic                              grant_i,
   output logic                              wr_o,
   output logic [ADDR_W-1:0]                 addr_o,
   output logic [IDX_W-1:0]                  index_o,
   output logic [DATA_W-1:0]                 data_o,
   output logic [$clog2(CMD_DEPTH+1)-1:0]    cmd_count_o,
   output logic [$clog2(DATA_DEPTH+1)-1:0]   data_count_o,
   output logic                              almost_full_o
);
   localparam int CW = $clog2(CMD_DEPTH + 1);
   localparam int DW = $clog2(DATA_DEPTH + 1);
   localparam int CP = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int DP = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

   logic [CP-1:0]     cmd_wp, cmd_rp, cmd_wp_nxt, cmd_rp_nxt;
   logic [DP-1:0]     dat_wp, dat_rp, dat_wp_nxt, dat_rp_nxt;
   logic [CW-1:0]     cmd_cnt;
   logic [DW-1:0]     dat_cnt;
   logic              cmd_wr   [CMD_DEPTH];
   logic [ADDR_W-1:0] cmd_addr [CMD_DEPTH];
   logic [IDX_W-1:0]  cmd_idx  [CMD_DEPTH];
   logic [DATA_W-1:0] dat_mem  [DATA_DEPTH];
   logic              push, pop, dpush, dpop, flush;

`ifdef SPLIT_FIFO_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   // Acceptance looks only at registered counts, so a same-cycle pop never frees a slot.
   assign grant_o = (cmd_cnt < CW'(CMD_DEPTH)) && (dat_cnt < DW'(DATA_DEPTH));
   assign valid_o = cmd_cnt != '0;
   assign push    = valid_i && grant_o;
   assign pop     = valid_o && grant_i;
   assign dpush   = push && wr_i;
   assign dpop    = pop && cmd_wr[cmd_rp];

   assign wr_o          = cmd_wr[cmd_rp];
   assign addr_o        = cmd_addr[cmd_rp];
   assign index_o       = cmd_idx[cmd_rp];
   assign data_o        = dat_mem[dat_rp];
   assign cmd_count_o   = cmd_cnt;
   assign data_count_o  = dat_cnt;
   assign almost_full_o = int'(cmd_cnt) >= AFULL_THR;

   always_comb begin
      cmd_wp_nxt = (cmd_wp == CP'(CMD_DEPTH - 1)) ? '0 : cmd_wp + 1'b1;
      cmd_rp_nxt = (cmd_rp == CP'(CMD_DEPTH - 1)) ? '0 : cmd_rp + 1'b1;
      dat_wp_nxt = (dat_wp == DP'(DATA_DEPTH - 1)) ? '0 : dat_wp + 1'b1;
      dat_rp_nxt = (dat_rp == DP'(DATA_DEPTH - 1)) ? '0 : dat_rp + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_wp  <= '0;
         cmd_rp  <= '0;
         dat_wp  <= '0;
         dat_rp  <= '0;
         cmd_cnt <= '0;
         dat_cnt <= '0;
         for (int i = 0; i < CMD_DEPTH; i++) begin
            cmd_wr[i]   <= 1'b0;
            cmd_addr[i] <= '0;
            cmd_idx[i]  <= '0;
         end
         for (int i = 0; i < DATA_DEPTH; i++) dat_mem[i] <= '0;
      end else if (flush) begin
         cmd_wp  <= '0;
         cmd_rp  <= '0;
         dat_wp  <= '0;
         dat_rp  <= '0;
         cmd_cnt <= '0;
         dat_cnt <= '0;
      end else begin
         if (push) begin
            cmd_wr[cmd_wp]   <= wr_i;
            cmd_addr[cmd_wp] <= addr_i;
            cmd_idx[cmd_wp]  <= index_i;
            cmd_wp           <= cmd_wp_nxt;
         end
         if (dpush) begin
            dat_mem[dat_wp] <= data_i;
            dat_wp          <= dat_wp_nxt;
         end
         if (pop) cmd_rp <= cmd_rp_nxt;
         if (dpop) dat_rp <= dat_rp_nxt;
         cmd_cnt <= cmd_cnt + CW'(push) - CW'(pop);
         dat_cnt <= dat_cnt + DW'(dpush) - DW'(dpop);
      end
   end
endmodule

// File: tb/tb_split_cmd_data_fifo.sv
// tb_split_cmd_data_fifo: directed checks on a 4/2 instance and a 3/2 instance for pointer wrap.
module tb_split_cmd_data_fifo;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush_i = 1'b0;
   logic       valid_i = 1'b0, grant_i = 1'b0, wr_i = 1'b0;
   logic [7:0] addr_i = '0, data_i = '0;
   logic [3:0] index_i = '0;
   logic       grant_o, valid_o, wr_o, almost_full_o;
   logic [7:0] addr_o, data_o;
   logic [3:0] index_o;
   logic [2:0] cmd_count_o;
   logic [1:0] data_count_o;

   logic       b_valid_i = 1'b0, b_grant_i = 1'b0, b_wr_i = 1'b0;
   logic [7:0] b_addr_i = '0, b_data_i = '0;
   logic       b_grant_o, b_valid_o, b_wr_o, b_almost_full_o;
   logic [7:0] b_addr_o, b_data_o;
   logic [3:0] b_index_o;
   logic [1:0] b_cmd_count_o, b_data_count_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   split_cmd_data_fifo #(.CMD_DEPTH(4), .DATA_DEPTH(2), .ADDR_W(8), .DATA_W(8), .IDX_W(4), .AFULL_THR(3)) u_dut (
      .clk(clk), .rst_n(rst_n),
`ifdef SPLIT_FIFO_FLUSH_EN
      .flush_i(flush_i),
`endif
      .valid_i(valid_i), .grant_o(grant_o), .wr_i(wr_i), .addr_i(addr_i), .data_i(data_i),
      .index_i(index_i), .valid_o(valid_o), .grant_i(grant_i), .wr_o(wr_o), .addr_o(addr_o),
      .index_o(index_o), .data_o(data_o), .cmd_count_o(cmd_count_o), .data_count_o(data_count_o),
      .almost_full_o(almost_full_o));

   split_cmd_data_fifo #(.CMD_DEPTH(3), .DATA_DEPTH(2), .ADDR_W(8), .DATA_W(8), .IDX_W(4), .AFULL_THR(2)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
`ifdef SPLIT_FIFO_FLUSH_EN
      .flush_i(1'b0),
`endif
      .valid_i(b_valid_i), .grant_o(b_grant_o), .wr_i(b_wr_i), .addr_i(b_addr_i), .data_i(b_data_i),
      .index_i(4'd0), .valid_o(b_valid_o), .grant_i(b_grant_i), .wr_o(b_wr_o), .addr_o(b_addr_o),
      .index_o(b_index_o), .data_o(b_data_o), .cmd_count_o(b_cmd_count_o), .data_count_o(b_data_count_o),
      .almost_full_o(b_almost_full_o));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [3:0] idx);
      valid_i = 1'b1; wr_i = w; addr_i = a; data_i = d; index_i = idx;
      step();
      valid_i = 1'b0;
   endtask

   task automatic pop();
      grant_i = 1'b1;
      step();
      grant_i = 1'b0;
   endtask

   initial begin
      step(); step();
      rst_n = 1'b1;
      chk("rst valid_o", valid_o, 0);
      chk("rst grant_o", grant_o, 1);
      chk("rst cmd_count", cmd_count_o, 0);
      chk("rst data_count", data_count_o, 0);
      chk("rst almost_full", almost_full_o, 0);
      chk("rst addr_o", addr_o, 0);
      chk("rst data_o", data_o, 0);

      push(1, 8'h10, 8'hAA, 4'd1);
      chk("w1 valid_o", valid_o, 1);
      chk("w1 grant_o", grant_o, 1);
      push(1, 8'h20, 8'hBB, 4'd2);
      chk("2w grant_o", grant_o, 0);
      chk("2w cmd_count", cmd_count_o, 2);
      chk("2w data_count", data_count_o, 2);
      chk("2w head addr", addr_o, 8'h10);
      chk("2w head data", data_o, 8'hAA);
      chk("2w head wr", wr_o, 1);
      pop();
      chk("pop1 addr", addr_o, 8'h20);
      chk("pop1 data", data_o, 8'hBB);
      chk("pop1 grant_o", grant_o, 1);
      chk("pop1 data_count", data_count_o, 1);
      pop();
      chk("drain valid_o", valid_o, 0);
      chk("drain data_count", data_count_o, 0);
      pop();
      chk("empty pop cmd_count", cmd_count_o, 0);
      chk("empty pop data_count", data_count_o, 0);

      push(0, 8'd1, 8'h00, 4'd1);
      chk("r1 afull", almost_full_o, 0);
      push(0, 8'd2, 8'h00, 4'd2);
      chk("r2 afull", almost_full_o, 0);
      push(0, 8'd3, 8'h00, 4'd3);
      chk("r3 afull", almost_full_o, 1);
      push(0, 8'd4, 8'h00, 4'd4);
      chk("r4 cmd_count", cmd_count_o, 4);
      chk("r4 data_count", data_count_o, 0);
      chk("r4 grant_o", grant_o, 0);
      chk("r4 afull", almost_full_o, 1);
      valid_i = 1'b1; wr_i = 1'b0; addr_i = 8'd5; index_i = 4'd5; grant_i = 1'b1;
      step();
      valid_i = 1'b0; grant_i = 1'b0;
      chk("full push+pop count", cmd_count_o, 3);
      chk("full push+pop head", addr_o, 8'd2);
      pop(); pop();
      chk("r tail addr", addr_o, 8'd4);
      pop();
      chk("r drained", cmd_count_o, 0);

      push(0, 8'd1, 8'h00, 4'd1);
      push(1, 8'd2, 8'hC1, 4'd2);
      push(0, 8'd3, 8'h00, 4'd3);
      chk("mix grant after 3", grant_o, 1);
      push(1, 8'd4, 8'hC2, 4'd4);
      chk("mix cmd_count", cmd_count_o, 4);
      chk("mix data_count", data_count_o, 2);
      chk("mix h1 idx", index_o, 1);
      chk("mix h1 wr", wr_o, 0);
      pop();
      chk("mix h2 idx", index_o, 2);
      chk("mix h2 wr", wr_o, 1);
      chk("mix h2 data", data_o, 8'hC1);
      pop();
      chk("mix h3 idx", index_o, 3);
      chk("mix h3 wr", wr_o, 0);
      chk("mix h3 data_count", data_count_o, 1);
      pop();
      chk("mix h4 idx", index_o, 4);
      chk("mix h4 data", data_o, 8'hC2);
      pop();
      chk("mix empty", valid_o, 0);
      chk("mix data empty", data_count_o, 0);

      push(1, 8'h31, 8'h55, 4'd7);
      push(0, 8'h32, 8'h00, 4'd8);
      rst_n = 1'b0; valid_i = 1'b1; wr_i = 1'b1; addr_i = 8'h77; data_i = 8'h66; grant_i = 1'b1;
      step();
      rst_n = 1'b1; valid_i = 1'b0; grant_i = 1'b0;
      chk("mid rst cmd_count", cmd_count_o, 0);
      chk("mid rst data_count", data_count_o, 0);
      chk("mid rst valid_o", valid_o, 0);
      chk("mid rst addr_o", addr_o, 0);
      chk("mid rst data_o", data_o, 0);

`ifdef SPLIT_FIFO_FLUSH_EN
      push(0, 8'd1, 8'h00, 4'd1);
      push(1, 8'd2, 8'h44, 4'd2);
      push(0, 8'd3, 8'h00, 4'd3);
      chk("pre flush count", cmd_count_o, 3);
      flush_i = 1'b1; valid_i = 1'b1; grant_i = 1'b1;
      step();
      flush_i = 1'b0; valid_i = 1'b0; grant_i = 1'b0;
      chk("flush cmd_count", cmd_count_o, 0);
      chk("flush data_count", data_count_o, 0);
      chk("flush valid_o", valid_o, 0);
      chk("flush grant_o", grant_o, 1);
`endif

      b_valid_i = 1'b1; b_wr_i = 1'b1; b_addr_i = 8'd100; b_data_i = 8'h50;
      step();
      b_grant_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         b_addr_i = 8'(101 + k);
         b_data_i = 8'(8'h51 + k);
         chk("wrap head addr", b_addr_o, 32'(100 + k));
         chk("wrap head data", b_data_o, 32'(8'h50 + k));
         chk("wrap cmd_count", b_cmd_count_o, 1);
         chk("wrap grant_o", b_grant_o, 1);
         step();
      end
      b_valid_i = 1'b0; b_grant_i = 1'b0;
      chk("wrap final addr", b_addr_o, 110);
      chk("wrap final data", b_data_o, 8'h5A);
      chk("wrap final data_count", b_data_count_o, 1);
      b_grant_i = 1'b1;
      step();
      b_grant_i = 1'b0;
      chk("wrap drained", b_cmd_count_o, 0);
      chk("wrap data drained", b_data_count_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
